pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush (sync clear)

---
 rtl/pipeline_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives pipeline register enables and
// bubble clears, and keeps saturating stall/flush counters plus a sticky memory-timeout flag.
module pipeline_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_pc_src,
    input  logic             i_ex_mdu_start,
    input  logic             i_mdu_done,
    input  logic             i_mem_req,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_memwb_flush,
    output logic [1:0]       o_ctrl_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count,
    output logic             o_mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    logic w_mem_block;
    logic w_load_use;
    logic w_branch;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_memwb_flush;

    // Once in MEM_WAIT only dmem_ready releases the stall; mem_req is not re-qualified.
    assign w_mem_block = (r_state == ST_MEM_WAIT) ? ~i_dmem_ready
                                                  : (i_mem_req & ~i_dmem_ready);
    assign w_load_use  = i_ex_mem_read & (i_ex_rd != '0) &
                         ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

    always_comb begin
        w_next        = r_state;
        w_branch      = 1'b0;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;

        if (!i_rst_n) begin
            w_next        = ST_RUN;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (w_mem_block) begin
            w_next        = ST_MEM_WAIT;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_flush = 1'b1;
        end else begin
            case (r_state)
                ST_MEM_WAIT: begin
                    // A multi-cycle op held in EX behind the memory stall starts its wait now.
                    w_next = i_ex_mdu_start ? ST_MDU_WAIT : ST_RUN;
                end
                ST_MDU_WAIT: begin
                    if (!i_mdu_done) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_flush = 1'b1;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                default: begin
                    if (i_ex_mdu_start) begin
                        w_next        = ST_MDU_WAIT;
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_flush = 1'b1;
                    end else if (i_ex_pc_src) begin
                        w_branch     = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Both event counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_branch && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    // The flag sets on the edge where the count of still-waiting MEM_WAIT cycles hits the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if ((r_state == ST_MEM_WAIT) && (w_next == ST_MEM_WAIT)) begin
            if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign o_pc_en        = w_pc_en;
    assign o_ifid_en      = w_ifid_en;
    assign o_idex_en      = w_idex_en;
    assign o_exmem_en     = w_exmem_en;
    assign o_memwb_en     = w_memwb_en;
    assign o_ifid_flush   = w_ifid_flush;
    assign o_idex_flush   = w_idex_flush;
    assign o_exmem_flush  = w_exmem_flush;
    assign o_memwb_flush  = w_memwb_flush;
    assign o_ctrl_state   = r_state;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
    assign o_mem_timeout  = r_mem_timeout;

endmodule
